gb_hist_sched: RTL and testbench
================================

// Module: gb_hist_sched
// PURPOSE
//   Frame scheduler for the gray-balance histogram RAM. Owns the single RAM port pair and time-shares it:
//   INIT clears all bins after reset; ACCUM increments bin[pixel] per accepted pixel (read-modify-write);
//   COMP hands the port to the compensation engine, which sweeps bins, builds the map and zeroes them.
//   Sits between the video input stream, the histogram RAM and the compensation engine.
// PARAMETERS
//   DIN_WIDTH   14  pixel width; histogram has 2^DIN_WIDTH bins
//   CNT_WIDTH   24  bin counter width (must hold max pixels per frame)
// PORTS
//   clk             in   1          clock
//   rst_n           in   1          asynchronous, active-low reset
//   in_valid        in   1          pixel valid
//   in_data         in   DIN_WIDTH  pixel value = bin address
//   in_endofpacket  in   1          last pixel of frame
//   in_ready        out  1          pixel accepted when in_valid & in_ready
//   ram_rd_addr     out  DIN_WIDTH  histogram RAM read address (1-cycle read latency)
//   ram_rd_q        in   CNT_WIDTH  histogram RAM read data
//   ram_wr_addr     out  DIN_WIDTH  histogram RAM write address
//   ram_wr_data     out  CNT_WIDTH  histogram RAM write data
//   ram_wr          out  1          histogram RAM write enable
//   comp_start      out  1          one-cycle start pulse to compensation engine
//   comp_busy       in   1          compensation engine active
//   comp_rd_addr    in   DIN_WIDTH  engine read address, routed to ram_rd_addr in COMP
//   comp_wr_addr    in   DIN_WIDTH  engine write address, routed to ram_wr_addr in COMP
//   comp_wr         in   1          engine write strobe, routed to ram_wr in COMP (data forced 0)
//   frame_cnt       out  16         completed frames, wraps 0xFFFF->0
// BEHAVIOUR
//   Reset: state=INIT; in_ready=0, comp_start=0, ram_wr=0, all addresses/data=0, frame_cnt=0, pipeline empty.
//   States (one-hot): INIT -> ACCUM -> DRAIN -> START -> COMP -> ACCUM.
//   INIT: ram_wr=1, ram_wr_data=0, ram_wr_addr=clr_cnt 0..2^DIN_WIDTH-1 (one per cycle); after last -> ACCUM.
//   ACCUM: in_ready=1. Accepted pixel at cycle t: ram_rd_addr=in_data at t; at t+1 write addr=same,
//     data=base+1, base = forwarded value if the previous cycle wrote the same address, else ram_rd_q.
//     RAM read-during-write returns old data; one-deep forwarding covers back-to-back equal pixels.
//     Accepted pixel with in_endofpacket -> DRAIN (in_ready drops next cycle).
//   DRAIN: in_ready=0; one cycle for the final RMW write to complete -> START.
//   START: comp_start=1 for exactly one cycle -> COMP; seen_busy cleared.
//   COMP: in_ready=0; RAM ports driven from comp_* inputs, ram_wr_data=0; seen_busy set when comp_busy=1;
//     comp_busy=0 with seen_busy=1 -> ACCUM, frame_cnt+1. No timeout; waits indefinitely for busy.
//   Stalls: in_valid low in ACCUM issues no read/write; pipeline advances with bubbles.
//   Reset mid-frame or mid-COMP: immediate return to INIT, full re-clear; partial histogram discarded.
//   Width: increment in CNT_WIDTH bits; overflow handling per CONFIGURATION.
// CONFIGURATION
//   GB_SATURATE_EN defined: bin increment saturates at 2^CNT_WIDTH-1 (write of all-ones repeated).
//   GB_SATURATE_EN undefined: increment wraps modulo 2^CNT_WIDTH (all-ones+1 -> 0).
// STRUCTURE
//   Package gb_pkg: state one-hot localparams (ST_INIT..ST_COMP), FRAME_CNT_W=16.
//   Sub-module gb_hist_rmw: 2-stage read-modify-write pipeline with forwarding and saturation option;
//   scheduler top holds FSM, clear counter, port mux, frame counter.
// TESTING
//   Reset release -> 2^DIN_WIDTH consecutive ram_wr with data 0, addr 0..max, then in_ready=1.
//   Pixels 5,5,5,7 back-to-back (bins 0) -> writes (5,1),(5,2),(5,3),(7,1); no lost increment.
//   Pixel 9 with eop -> in_ready low, comp_start pulse exactly 2 cycles after eop accept, ports muxed.
//   comp_busy high 10 cycles then low -> return to ACCUM, frame_cnt 0->1; comp_wr writes data 0.
//   Bin preloaded all-ones, pixel hits it -> all-ones with GB_SATURATE_EN, 0 without.
//   rst_n asserted during COMP -> state INIT, comp_start stays 0, clear sweep restarts at addr 0.

Source files
------------

// File: rtl/gb_hist_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : gb_pkg                                                     |
// | Shared state encodings and widths for the gray-balance histogram     |
// | frame scheduler.                                                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package gb_pkg;

    localparam int FRAME_CNT_W = 16;

    localparam logic [4:0] ST_INIT  = 5'b00001;
    localparam logic [4:0] ST_ACCUM = 5'b00010;
    localparam logic [4:0] ST_DRAIN = 5'b00100;
    localparam logic [4:0] ST_START = 5'b01000;
    localparam logic [4:0] ST_COMP  = 5'b10000;

    typedef enum logic [4:0] {
        S_INIT  = ST_INIT,
        S_ACCUM = ST_ACCUM,
        S_DRAIN = ST_DRAIN,
        S_START = ST_START,
        S_COMP  = ST_COMP
    } state_e;

endpackage
`default_nettype wire

// File: rtl/gb_hist_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : gb_hist_sched_if                                         |
// | Pixel stream, histogram RAM port pair and compensation-engine        |
// | handshake of the histogram frame scheduler.                          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface gb_hist_sched_if #(
    parameter int DIN_WIDTH = 14,
    parameter int CNT_WIDTH = 24
);
    import gb_pkg::*;

    logic                   in_valid;
    logic [DIN_WIDTH-1:0]   in_data;
    logic                   in_endofpacket;
    logic                   in_ready;

    logic [DIN_WIDTH-1:0]   ram_rd_addr;
    logic [CNT_WIDTH-1:0]   ram_rd_q;
    logic [DIN_WIDTH-1:0]   ram_wr_addr;
    logic [CNT_WIDTH-1:0]   ram_wr_data;
    logic                   ram_wr;

    logic                   comp_start;
    logic                   comp_busy;
    logic [DIN_WIDTH-1:0]   comp_rd_addr;
    logic [DIN_WIDTH-1:0]   comp_wr_addr;
    logic                   comp_wr;

    logic [FRAME_CNT_W-1:0] frame_cnt;

    // Scheduler side
    modport master (
        input  in_valid, in_data, in_endofpacket, ram_rd_q,
               comp_busy, comp_rd_addr, comp_wr_addr, comp_wr,
        output in_ready, ram_rd_addr, ram_wr_addr, ram_wr_data, ram_wr,
               comp_start, frame_cnt
    );

    // Environment side: video source, RAM and compensation engine
    modport slave (
        output in_valid, in_data, in_endofpacket, ram_rd_q,
               comp_busy, comp_rd_addr, comp_wr_addr, comp_wr,
        input  in_ready, ram_rd_addr, ram_wr_addr, ram_wr_data, ram_wr,
               comp_start, frame_cnt
    );

endinterface
`default_nettype wire

// File: rtl/gb_hist_sched_rmw.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : gb_hist_rmw                                                |
// | Two-stage histogram read-modify-write with one-deep forwarding.      |
// | GB_SATURATE_EN: saturate bins at all-ones instead of wrapping.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module gb_hist_rmw
    import gb_pkg::*;
#(
    parameter int DIN_WIDTH = 14,
    parameter int CNT_WIDTH = 24
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic                 acc_valid,
    input  wire logic [DIN_WIDTH-1:0] acc_addr,
    input  wire logic [CNT_WIDTH-1:0] rd_q,
    output logic                      wr,
    output logic [DIN_WIDTH-1:0]      wr_addr,
    output logic [CNT_WIDTH-1:0]      wr_data
);

    localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;

    logic                 r_s1_valid;
    logic [DIN_WIDTH-1:0] r_s1_addr;
    logic                 r_fwd_valid;
    logic [DIN_WIDTH-1:0] r_fwd_addr;
    logic [CNT_WIDTH-1:0] r_fwd_data;
    logic [CNT_WIDTH-1:0] w_base;
    logic [CNT_WIDTH-1:0] w_next;

    // RAM returns old data on read-during-write, so the write landing in
    // the same cycle as our read must be forwarded.
    always_comb begin
        w_base = (r_fwd_valid && (r_fwd_addr == r_s1_addr)) ? r_fwd_data : rd_q;
`ifdef GB_SATURATE_EN
        w_next = (w_base == c_cnt_max) ? c_cnt_max : (w_base + c_cnt_one);
`else
        w_next = w_base + c_cnt_one;
`endif
        wr      = r_s1_valid;
        wr_addr = r_s1_addr;
        wr_data = w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_addr   <= '0;
            r_fwd_valid <= 1'b0;
            r_fwd_addr  <= '0;
            r_fwd_data  <= '0;
        end else begin
            r_s1_valid  <= acc_valid;
            r_s1_addr   <= acc_addr;
            r_fwd_valid <= r_s1_valid;
            r_fwd_addr  <= r_s1_addr;
            r_fwd_data  <= w_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/gb_hist_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : gb_hist_sched                                              |
// | Time-shares the histogram RAM between clear, accumulate and the      |
// | compensation engine. GB_SATURATE_EN selects saturating bins.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module gb_hist_sched
    import gb_pkg::*;
#(
    parameter int DIN_WIDTH = 14,
    parameter int CNT_WIDTH = 24
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    gb_hist_sched_if.master   bus
);

    localparam logic [DIN_WIDTH-1:0]   c_clr_last  = '1;
    localparam logic [DIN_WIDTH-1:0]   c_addr_one  = DIN_WIDTH'(1);
    localparam logic [FRAME_CNT_W-1:0] c_frame_one = FRAME_CNT_W'(1);

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [DIN_WIDTH-1:0]   r_clr_cnt;
    logic                   r_clr_live;
    logic                   r_seen_busy;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;
    logic                   w_accept;
    logic                   w_rmw_wr;
    logic [DIN_WIDTH-1:0]   w_rmw_addr;
    logic [CNT_WIDTH-1:0]   w_rmw_data;

    assign w_accept      = bus.in_valid && (r_state == S_ACCUM);
    assign bus.frame_cnt = r_frame_cnt;

    gb_hist_rmw #(
        .DIN_WIDTH (DIN_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_rmw (
        .clk       (clk),
        .rst_n     (rst_n),
        .acc_valid (w_accept),
        .acc_addr  (bus.in_data),
        .rd_q      (bus.ram_rd_q),
        .wr        (w_rmw_wr),
        .wr_addr   (w_rmw_addr),
        .wr_data   (w_rmw_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_INIT;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt     = r_state;
        bus.in_ready    = 1'b0;
        bus.comp_start  = 1'b0;
        bus.ram_rd_addr = '0;
        bus.ram_wr_addr = '0;
        bus.ram_wr_data = '0;
        bus.ram_wr      = 1'b0;
        case (r_state)
            S_INIT: begin
                bus.ram_wr      = r_clr_live;
                bus.ram_wr_addr = r_clr_cnt;
                if (r_clr_live && (r_clr_cnt == c_clr_last)) w_state_nxt = S_ACCUM;
            end
            S_ACCUM, S_DRAIN: begin
                bus.in_ready    = (r_state == S_ACCUM);
                bus.ram_rd_addr = w_accept ? bus.in_data : '0;
                bus.ram_wr      = w_rmw_wr;
                bus.ram_wr_addr = w_rmw_addr;
                bus.ram_wr_data = w_rmw_data;
                if (r_state == S_DRAIN)                      w_state_nxt = S_START;
                else if (w_accept && bus.in_endofpacket)     w_state_nxt = S_DRAIN;
            end
            S_START: begin
                bus.comp_start = 1'b1;
                w_state_nxt    = S_COMP;
            end
            S_COMP: begin
                bus.ram_rd_addr = bus.comp_rd_addr;
                bus.ram_wr_addr = bus.comp_wr_addr;
                bus.ram_wr      = bus.comp_wr;
                if (!bus.comp_busy && r_seen_busy) w_state_nxt = S_ACCUM;
            end
            default: w_state_nxt = S_INIT;
        endcase
    end

    // Clear sweep idles one cycle after reset so no write is issued while
    // reset is still asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_cnt   <= '0;
            r_clr_live  <= 1'b0;
            r_seen_busy <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            if (r_state == S_INIT) begin
                r_clr_live <= !(r_clr_live && (r_clr_cnt == c_clr_last));
                if (r_clr_live) r_clr_cnt <= r_clr_cnt + c_addr_one;
            end
            if (r_state == S_START)
                r_seen_busy <= 1'b0;
            else if ((r_state == S_COMP) && bus.comp_busy)
                r_seen_busy <= 1'b1;
            if ((r_state == S_COMP) && !bus.comp_busy && r_seen_busy)
                r_frame_cnt <= r_frame_cnt + c_frame_one;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gb_hist_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_gb_hist_sched                                           |
// | Directed scoreboard bench for gb_hist_sched with a behavioural RAM.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_gb_hist_sched;

    localparam int DW = 6;
    localparam int CW = 8;
    localparam int NB = 1 << DW;

    typedef struct packed {
        logic [DW-1:0] addr;
        logic [CW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    wr_t  exp_q[$];

    logic          pl_en = 1'b0;
    logic [DW-1:0] pl_addr = '0;
    logic [CW-1:0] pl_data = '0;
    logic [CW-1:0] mem [NB];

`ifdef GB_SATURATE_EN
    localparam logic [CW-1:0] SAT_EXP = '1;
`else
    localparam logic [CW-1:0] SAT_EXP = '0;
`endif

    gb_hist_sched_if #(.DIN_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    gb_hist_sched #(.DIN_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // Single-port-pair RAM, 1-cycle read latency, old data on read-during-write
    always @(posedge clk) begin
        if (pl_en)      mem[pl_addr] <= pl_data;
        if (bus.ram_wr) mem[bus.ram_wr_addr] <= bus.ram_wr_data;
        bus.ram_rd_q <= mem[bus.ram_rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        wr_t e;
        @(negedge clk);
        if (mon_en && bus.ram_wr) begin
            chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(bus.ram_wr_addr), 32'(e.addr));
                chk("wr_data", 32'(bus.ram_wr_data), 32'(e.data));
            end
        end
    endtask

    task automatic push(input int a, input int d);
        wr_t e;
        e.addr = DW'(a);
        e.data = CW'(d);
        exp_q.push_back(e);
    endtask

    task automatic pixel(input int v, input bit eop);
        bus.in_valid       = 1'b1;
        bus.in_data        = DW'(v);
        bus.in_endofpacket = eop;
        tick();
        bus.in_valid       = 1'b0;
        bus.in_endofpacket = 1'b0;
    endtask

    task automatic preload(input int a, input int d);
        pl_en   = 1'b1;
        pl_addr = DW'(a);
        pl_data = CW'(d);
        tick();
        pl_en   = 1'b0;
    endtask

    task automatic clear_sweep(input string tag);
        bit seen = 1'b0;
        int nok  = 0;
        for (int k = 0; k < 8 && !seen; k++) begin
            tick();
            seen = bus.ram_wr;
        end
        chk({tag, "_start"}, 32'(seen), 32'd1);
        chk({tag, "_addr0"}, 32'(bus.ram_wr_addr), 32'd0);
        for (int i = 0; i < NB; i++) begin
            if (bus.ram_wr === 1'b1 && bus.ram_wr_addr === DW'(i) && bus.ram_wr_data === '0)
                nok++;
            tick();
        end
        chk({tag, "_sweep"}, 32'(nok), 32'(NB));
        chk({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_wr_off"}, 32'(bus.ram_wr), 32'd0);
    endtask

    initial begin
        rst_n              = 1'b0;
        bus.in_valid       = 1'b0;
        bus.in_data        = '0;
        bus.in_endofpacket = 1'b0;
        bus.comp_busy      = 1'b0;
        bus.comp_rd_addr   = '0;
        bus.comp_wr_addr   = '0;
        bus.comp_wr        = 1'b0;
        repeat (3) tick();

        chk("rst_in_ready",   32'(bus.in_ready),    32'd0);
        chk("rst_ram_wr",     32'(bus.ram_wr),      32'd0);
        chk("rst_comp_start", 32'(bus.comp_start),  32'd0);
        chk("rst_frame_cnt",  32'(bus.frame_cnt),   32'd0);
        chk("rst_wr_addr",    32'(bus.ram_wr_addr), 32'd0);
        chk("rst_rd_addr",    32'(bus.ram_rd_addr), 32'd0);

        rst_n = 1'b1;
        clear_sweep("init");

        // Back-to-back equal pixels exercise forwarding; bubble then revisit
        mon_en = 1'b1;
        push(5, 1); push(5, 2); push(5, 3); push(7, 1); push(5, 4);
        pixel(5, 1'b0); pixel(5, 1'b0); pixel(5, 1'b0); pixel(7, 1'b0);
        tick();
        pixel(5, 1'b0);
        tick(); tick();
        chk("rmw_all_written", 32'(exp_q.size()), 32'd0);

        // Bin at all-ones
        preload(20, 255);
        preload(44, 8'h5A);
        push(20, 32'(SAT_EXP));
        pixel(20, 1'b0);
        tick();
        chk("sat_written", 32'(exp_q.size()), 32'd0);

        // End of frame
        push(9, 1);
        bus.in_valid       = 1'b1;
        bus.in_data        = DW'(9);
        bus.in_endofpacket = 1'b1;
        #1;
        chk("eop_rd_addr",  32'(bus.ram_rd_addr), 32'd9);
        chk("eop_in_ready", 32'(bus.in_ready),    32'd1);
        tick();
        bus.in_valid       = 1'b0;
        bus.in_endofpacket = 1'b0;
        chk("drain_ready",  32'(bus.in_ready),   32'd0);
        chk("drain_start",  32'(bus.comp_start), 32'd0);
        chk("eop_written",  32'(exp_q.size()),   32'd0);
        mon_en = 1'b0;
        tick();
        chk("start_pulse",  32'(bus.comp_start), 32'd1);
        chk("start_ready",  32'(bus.in_ready),   32'd0);
        tick();
        chk("start_one_cycle", 32'(bus.comp_start), 32'd0);

        bus.comp_rd_addr = DW'(33);
        bus.comp_wr_addr = DW'(44);
        bus.comp_wr      = 1'b1;
        #1;
        chk("comp_rd_mux",  32'(bus.ram_rd_addr), 32'd33);
        chk("comp_wr_mux",  32'(bus.ram_wr_addr), 32'd44);
        chk("comp_wr_en",   32'(bus.ram_wr),      32'd1);
        chk("comp_wr_data", 32'(bus.ram_wr_data), 32'd0);
        tick();
        bus.comp_wr = 1'b0;
        chk("comp_wait_busy", 32'(bus.in_ready), 32'd0);
        chk("comp_fc_hold",   32'(bus.frame_cnt), 32'd0);
        chk("comp_zeroed",    32'(mem[44]),       32'd0);

        bus.comp_busy = 1'b1;
        begin
            int nready = 0;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (bus.in_ready !== 1'b0) nready++;
            end
            chk("comp_busy_ready", 32'(nready), 32'd0);
        end
        bus.comp_busy = 1'b0;
        tick();
        chk("comp_done_ready", 32'(bus.in_ready),  32'd1);
        chk("frame_cnt_1",     32'(bus.frame_cnt), 32'd1);

        // Second frame, reset while the engine is busy
        mon_en = 1'b1;
        push(3, 1);
        pixel(3, 1'b1);
        tick();
        chk("f2_written", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;
        chk("f2_start", 32'(bus.comp_start), 32'd1);
        tick();
        bus.comp_busy = 1'b1;
        repeat (3) tick();
        rst_n = 1'b0;
        bus.comp_busy = 1'b0;
        #1;
        chk("rst2_in_ready",   32'(bus.in_ready),   32'd0);
        chk("rst2_comp_start", 32'(bus.comp_start), 32'd0);
        chk("rst2_ram_wr",     32'(bus.ram_wr),     32'd0);
        chk("rst2_frame_cnt",  32'(bus.frame_cnt),  32'd0);
        tick(); tick();
        chk("rst2_hold_start", 32'(bus.comp_start), 32'd0);
        rst_n = 1'b1;
        clear_sweep("reinit");
        chk("reinit_start", 32'(bus.comp_start), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
